// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined shifter.
package shifter_pkg;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_e;

  // First shift level handled by a stage; stage == stages yields the level count.
  function automatic int unsigned stage_first_level(input int unsigned stage,
                                                    input int unsigned levels,
                                                    input int unsigned stages);
    return (stage * levels) / stages;
  endfunction

  // Stage that owns a given shift level.
  function automatic int unsigned level_stage(input int unsigned level,
                                              input int unsigned levels,
                                              input int unsigned stages);
    int unsigned res;
    res = 0;
    for (int unsigned s = 0; s < stages; s++) begin
      if (level >= stage_first_level(s, levels, stages)) res = s;
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational shift level: moves data by 2**Level when enabled.
module shift_level
  import shifter_pkg::*;
#(
  parameter int unsigned BitWidth = 32,
  parameter int unsigned Level    = 0
) (
  input  logic [BitWidth-1:0] in_data,
  input  logic                en,
  input  shift_op_e           op,
  input  logic                sign,
  output logic [BitWidth-1:0] out_data
);

  localparam int unsigned Dist = 1 << Level;

  // Select the moved operand; unknown op encodings fall back to SLL.
  always_comb begin
    out_data = in_data;
    if (en) begin
      case (op)
        SHIFT_SRL: out_data = in_data >> Dist;
        SHIFT_SRA: out_data = {{Dist{sign}}, in_data[BitWidth-1:Dist]};
        SHIFT_ROL: out_data = {in_data[BitWidth-Dist-1:0], in_data[BitWidth-1:BitWidth-Dist]};
        SHIFT_ROR: out_data = {in_data[Dist-1:0], in_data[BitWidth-1:Dist]};
        default:   out_data = in_data << Dist;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROL/ROR unit with valid/ready handshake and tag passthrough.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned BitWidth  = 32,
  parameter int unsigned NumStages = 2,
  parameter int unsigned TagWidth  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BitWidth-1:0]         in_data,
  input  logic [$clog2(BitWidth)-1:0] in_amount,
  input  shift_op_e                   in_op,
  input  logic [TagWidth-1:0]         in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BitWidth-1:0]         out_data,
  output logic [TagWidth-1:0]         out_tag
);

  localparam int unsigned Levels = $clog2(BitWidth);

  // Stage registers
  logic                st_valid [NumStages];
  logic [BitWidth-1:0] st_data  [NumStages];
  logic [Levels-1:0]   st_amt   [NumStages];
  shift_op_e           st_op    [NumStages];
  logic                st_sign  [NumStages];
  logic [TagWidth-1:0] st_tag   [NumStages];

  // Values entering each stage, and the data leaving its last level
  logic                si_valid [NumStages];
  logic [BitWidth-1:0] si_data  [NumStages];
  logic [Levels-1:0]   si_amt   [NumStages];
  shift_op_e           si_op    [NumStages];
  logic                si_sign  [NumStages];
  logic [TagWidth-1:0] si_tag   [NumStages];
  logic [BitWidth-1:0] so_data  [NumStages];

  logic [BitWidth-1:0] lvl_in  [Levels];
  logic [BitWidth-1:0] lvl_out [Levels];

  logic adv;
  logic [NumStages-1:0] unused_ctrl;

  // Whole pipe moves together; a bubble at the tail never blocks the head.
  assign out_valid = st_valid[NumStages-1];
  assign out_data  = st_data[NumStages-1];
  assign out_tag   = st_tag[NumStages-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign si_valid[s] = in_valid & in_ready;
      assign si_data[s]  = in_data;
      assign si_amt[s]   = in_amount;
      assign si_op[s]    = in_op;
      assign si_sign[s]  = in_data[BitWidth-1];
      assign si_tag[s]   = in_tag;
    end else begin : g_body
      assign si_valid[s] = st_valid[s-1];
      assign si_data[s]  = st_data[s-1];
      assign si_amt[s]   = st_amt[s-1];
      assign si_op[s]    = st_op[s-1];
      assign si_sign[s]  = st_sign[s-1];
      assign si_tag[s]   = st_tag[s-1];
    end
    assign so_data[s] = lvl_out[stage_first_level(s + 1, Levels, NumStages) - 1];
    // Control fields are not consumed by every stage (the tail ones feed nothing).
    assign unused_ctrl[s] = ^{st_amt[s], st_op[s], st_sign[s]};
  end

  for (genvar k = 0; k < Levels; k++) begin : g_level
    localparam int unsigned Stg   = level_stage(k, Levels, NumStages);
    localparam int unsigned First = stage_first_level(Stg, Levels, NumStages);
    if (k == First) begin : g_first
      assign lvl_in[k] = si_data[Stg];
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end
    shift_level #(
      .BitWidth(BitWidth),
      .Level   (k)
    ) u_level (
      .in_data (lvl_in[k]),
      .en      (si_amt[Stg][k]),
      .op      (si_op[Stg]),
      .sign    (si_sign[Stg]),
      .out_data(lvl_out[k])
    );
  end

  // Stage registers: flush on reset, load from predecessor when advancing, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NumStages; s++) begin
        st_valid[s] <= 1'b0;
        st_data[s]  <= '0;
        st_amt[s]   <= '0;
        st_op[s]    <= SHIFT_SLL;
        st_sign[s]  <= 1'b0;
        st_tag[s]   <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < NumStages; s++) begin
        st_valid[s] <= si_valid[s];
        st_data[s]  <= so_data[s];
        st_amt[s]   <= si_amt[s];
        st_op[s]    <= si_op[s];
        st_sign[s]  <= si_sign[s];
        st_tag[s]   <= si_tag[s];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench: directed tests on a 32/2 instance plus random sweeps
// on 32/1, 32/3, 32/5 and 64/3 instances against a behavioural model.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance stimulus
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_amt;
  shift_op_e   m_op;
  logic [4:0]  m_tag;
  logic [31:0] m_exp;
  bit          m_timed;

  // Sweep instance stimulus
  logic        s_valid;
  logic [63:0] s_data;
  logic [5:0]  s_amt;
  shift_op_e   s_op;
  logic [4:0]  s_tag;

  logic        ir   [5];
  logic        ov   [5];
  logic [31:0] od32 [4];
  logic [63:0] od64;
  logic [4:0]  ot   [5];

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$], q4[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit acc0;

  pipelined_shifter #(.BitWidth(32), .NumStages(2), .TagWidth(5)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(ir[0]), .in_data(m_data),
    .in_amount(m_amt), .in_op(m_op), .in_tag(m_tag), .out_valid(ov[0]),
    .out_ready(m_ready), .out_data(od32[0]), .out_tag(ot[0])
  );

  pipelined_shifter #(.BitWidth(32), .NumStages(1), .TagWidth(5)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(ir[1]), .in_data(s_data[31:0]),
    .in_amount(s_amt[4:0]), .in_op(s_op), .in_tag(s_tag), .out_valid(ov[1]),
    .out_ready(1'b1), .out_data(od32[1]), .out_tag(ot[1])
  );

  pipelined_shifter #(.BitWidth(32), .NumStages(3), .TagWidth(5)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(ir[2]), .in_data(s_data[31:0]),
    .in_amount(s_amt[4:0]), .in_op(s_op), .in_tag(s_tag), .out_valid(ov[2]),
    .out_ready(1'b1), .out_data(od32[2]), .out_tag(ot[2])
  );

  pipelined_shifter #(.BitWidth(32), .NumStages(5), .TagWidth(5)) u_s5 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(ir[3]), .in_data(s_data[31:0]),
    .in_amount(s_amt[4:0]), .in_op(s_op), .in_tag(s_tag), .out_valid(ov[3]),
    .out_ready(1'b1), .out_data(od32[3]), .out_tag(ot[3])
  );

  pipelined_shifter #(.BitWidth(64), .NumStages(3), .TagWidth(5)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(ir[4]), .in_data(s_data),
    .in_amount(s_amt), .in_op(s_op), .in_tag(s_tag), .out_valid(ov[4]),
    .out_ready(1'b1), .out_data(od64), .out_tag(ot[4])
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required end", cyc);
    $fatal(1);
  end

  function automatic int lat_of(input int id);
    case (id)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 3;
    endcase
  endfunction

  // Reference model written with whole-word operators.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int unsigned amt,
                                            input logic [2:0] op, input int unsigned w);
    logic [63:0] mask, dm, r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    dm   = d & mask;
    case (op)
      3'd1: r = dm >> amt;
      3'd2: r = dm[w-1] ? ((dm >> amt) | ~(mask >> amt)) : (dm >> amt);
      3'd3: r = (dm << amt) | (dm >> (w - amt));
      3'd4: r = (dm >> amt) | (dm << (w - amt));
      default: r = dm << amt;
    endcase
    return r & mask;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic pop(input int id, output exp_t e, output bit ok);
    ok = (qsize(id) > 0);
    if (ok) begin
      case (id)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        3: e = q3.pop_front();
        default: e = q4.pop_front();
      endcase
    end
  endtask

  // One clock: record accepts and check handoffs just before the edge.
  task automatic cycle();
    exp_t        e;
    bit          ok;
    logic [63:0] obs;
    logic        rdy;
    @(negedge clk);
    acc0 = m_valid && ir[0] && !rst;
    if (!rst) begin
      if (acc0) push(0, '{{32'b0, m_exp}, m_tag, m_timed ? cyc + 2 : -1});
      for (int id = 1; id < 5; id++) begin
        if (s_valid && ir[id]) begin
          if (id == 4) push(id, '{ref_shift(s_data, s_amt, s_op, 64), s_tag, cyc + lat_of(id)});
          else push(id, '{ref_shift(s_data, {1'b0, s_amt[4:0]}, s_op, 32), s_tag,
                          cyc + lat_of(id)});
        end
      end
      for (int id = 0; id < 5; id++) begin
        rdy = (id == 0) ? m_ready : 1'b1;
        if (ov[id] && rdy) begin
          pop(id, e, ok);
          obs = (id == 4) ? od64 : {32'b0, od32[id]};
          if (!ok) begin
            chk($sformatf("u%0d_unexpected_out", id), {63'b0, ov[id]}, 64'd0);
          end else begin
            chk($sformatf("u%0d_data", id), obs, e.data);
            chk($sformatf("u%0d_tag", id), {59'b0, ot[id]}, {59'b0, e.tag});
            if (e.cyc >= 0) chk($sformatf("u%0d_latency", id), 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send0(input shift_op_e op, input logic [31:0] d, input logic [4:0] a,
                       input logic [4:0] t, input logic [31:0] e, input bit timed);
    m_valid = 1'b1;
    m_op    = op;
    m_data  = d;
    m_amt   = a;
    m_tag   = t;
    m_exp   = e;
    m_timed = timed;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc0) break;
    end
    if (!acc0) chk("accept_timeout", {63'b0, acc0}, 64'd1);
  endtask

  task automatic drain(input int n);
    m_valid = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst     = 1'b1;
    m_valid = 1'b0;
    m_ready = 1'b1;
    m_data  = '0;
    m_amt   = '0;
    m_op    = SHIFT_SLL;
    m_tag   = '0;
    m_exp   = '0;
    m_timed = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_amt   = '0;
    s_op    = SHIFT_SLL;
    s_tag   = '0;
    acc0    = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
    chk("reset_in_ready", {63'b0, ir[0]}, 64'd1);
    chk("reset_out_valid", {63'b0, ov[0]}, 64'd0);
    chk("reset_out_data", {32'b0, od32[0]}, 64'd0);
    chk("reset_out_tag", {59'b0, ot[0]}, 64'd0);

    // Single SRA with tag echo and exact latency
    send0(SHIFT_SRA, 32'h8000_0000, 5'd4, 5'h0A, 32'hF800_0000, 1'b1);
    drain(6);

    // Back-to-back directed sweep
    send0(SHIFT_SLL, 32'h0000_0001, 5'd31, 5'd1, 32'h8000_0000, 1'b1);
    send0(SHIFT_SRL, 32'hFFFF_FFFF, 5'd0, 5'd2, 32'hFFFF_FFFF, 1'b1);
    send0(SHIFT_ROL, 32'h8000_0001, 5'd1, 5'd3, 32'h0000_0003, 1'b1);
    send0(SHIFT_ROR, 32'h0000_0001, 5'd1, 5'd4, 32'h8000_0000, 1'b1);
    // Illegal op behaves as SLL
    send0(shift_op_e'(3'b111), 32'h0000_000F, 5'd4, 5'd5, 32'h0000_00F0, 1'b1);
    drain(6);

    // Backpressure: two accepts fill the pipe, then everything holds
    m_ready = 1'b0;
    send0(SHIFT_SLL, 32'h0000_0001, 5'd4, 5'd11, 32'h0000_0010, 1'b0);
    send0(SHIFT_SRL, 32'h0000_00F0, 5'd4, 5'd12, 32'h0000_000F, 1'b0);
    m_op   = SHIFT_ROR;
    m_data = 32'h0000_0003;
    m_amt  = 5'd1;
    m_tag  = 5'd13;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_in_ready", {63'b0, ir[0]}, 64'd0);
      chk("stall_out_valid", {63'b0, ov[0]}, 64'd1);
      chk("stall_out_data", {32'b0, od32[0]}, 64'h10);
      chk("stall_out_tag", {59'b0, ot[0]}, 64'd11);
    end
    m_ready = 1'b1;
    send0(SHIFT_ROR, 32'h0000_0003, 5'd1, 5'd13, 32'h8000_0001, 1'b0);
    send0(SHIFT_SRA, 32'h8000_0000, 5'd31, 5'd14, 32'hFFFF_FFFF, 1'b0);
    drain(6);
    chk("backpressure_drained", 64'(qsize(0)), 64'd0);

    // Reset with two operations in flight
    m_ready = 1'b0;
    send0(SHIFT_SLL, 32'h0000_AAAA, 5'd8, 5'd21, 32'h00AA_AA00, 1'b0);
    send0(SHIFT_SRL, 32'h1234_5678, 5'd16, 5'd22, 32'h0000_1234, 1'b0);
    m_valid = 1'b0;
    rst     = 1'b1;
    cycle();
    rst = 1'b0;
    q0.delete();
    chk("midreset_out_valid", {63'b0, ov[0]}, 64'd0);
    chk("midreset_out_data", {32'b0, od32[0]}, 64'd0);
    chk("midreset_in_ready", {63'b0, ir[0]}, 64'd1);
    m_ready = 1'b1;
    drain(6);

    // Random sweep over the other parameterisations
    for (int i = 0; i < 300; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = {$urandom, $urandom};
      s_amt   = 6'($urandom_range(0, 63));
      s_op    = shift_op_e'($urandom_range(0, 7));
      s_tag   = 5'($urandom_range(0, 31));
      cycle();
    end
    drain(10);
    for (int id = 0; id < 5; id++) chk($sformatf("u%0d_queue_empty", id), 64'(qsize(id)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
